// File: rtl/pulse_width_meter_if.sv
// Line-timer bus: groups the edge/tick inputs and the capture/strobe outputs
// of pulse_width_meter so the block plugs into the receive pipeline as one port.
// Latency: n/a (wiring only). Backpressure: none, all strobes are fire-and-forget.
//
// Ports (signals):
//   i_count_enable, i_rising, i_falling, i_clear   -> driven by the master side
//   o_count, o_saturated, o_high_width, o_high_valid, o_low_width, o_low_valid,
//   o_break, o_frame_start, o_error, o_state        -> driven by the slave (meter)
interface pulse_width_meter_if #(
  parameter int WIDTH = 10
);
  logic             i_count_enable;
  logic             i_rising;
  logic             i_falling;
  logic             i_clear;
  logic [WIDTH-1:0] o_count;
  logic             o_saturated;
  logic [WIDTH-1:0] o_high_width;
  logic             o_high_valid;
  logic [WIDTH-1:0] o_low_width;
  logic             o_low_valid;
  logic             o_break;
  logic             o_frame_start;
  logic             o_error;
  logic [1:0]       o_state;

  // Upstream side: edge detector / tick generator / control.
  modport master (
    output i_count_enable, i_rising, i_falling, i_clear,
    input  o_count, o_saturated, o_high_width, o_high_valid, o_low_width,
    input  o_low_valid, o_break, o_frame_start, o_error, o_state
  );

  // The meter itself.
  modport slave (
    input  i_count_enable, i_rising, i_falling, i_clear,
    output o_count, o_saturated, o_high_width, o_high_valid, o_low_width,
    output o_low_valid, o_break, o_frame_start, o_error, o_state
  );
endinterface

// File: rtl/pulse_width_meter.sv
// WS2812 line timer: counts ticks between edges, captures high/low times, flags breaks.
// Latency: captures and strobes appear one cycle after the edge cycle; o_saturated is combinational.
// Backpressure: none; each strobe is high for exactly one cycle and must be consumed then.
//
// Ports:
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset (clears every register, state IDLE)
//   bus        pulse_width_meter_if.slave: tick/edge/clear in, count/captures/strobes/state out
module pulse_width_meter #(
  parameter int WIDTH       = 10,
  parameter int RESET_TICKS = 400
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  pulse_width_meter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH-1:0] BREAK_CNT = WIDTH'(RESET_TICKS);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_high_width;
  logic [WIDTH-1:0] r_low_width;
  logic             r_high_valid;
  logic             r_low_valid;
  logic             r_break;
  logic             r_frame_start;
  logic             r_error;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_high_width_next;
  logic [WIDTH-1:0] w_low_width_next;
  logic             w_high_valid_next;
  logic             w_low_valid_next;
  logic             w_break_next;
  logic             w_frame_start_next;
  logic             w_error_next;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_high_width  <= '0;
      r_low_width   <= '0;
      r_high_valid  <= 1'b0;
      r_low_valid   <= 1'b0;
      r_break       <= 1'b0;
      r_frame_start <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_count       <= w_count_next;
      r_high_width  <= w_high_width_next;
      r_low_width   <= w_low_width_next;
      r_high_valid  <= w_high_valid_next;
      r_low_valid   <= w_low_valid_next;
      r_break       <= w_break_next;
      r_frame_start <= w_frame_start_next;
      r_error       <= w_error_next;
    end
  end

  // Priority: clear, then both edges, then a single edge, then plain counting.
  // Captures take r_count as it stood before the edge cycle; an edge always
  // restarts the counter at 0 regardless of the tick strobe.
  always_comb begin
    w_state_next       = r_state;
    w_count_next       = r_count;
    w_high_width_next  = r_high_width;
    w_low_width_next   = r_low_width;
    w_high_valid_next  = 1'b0;
    w_low_valid_next   = 1'b0;
    w_break_next       = 1'b0;
    w_frame_start_next = 1'b0;
    w_error_next       = 1'b0;

    if (bus.i_clear) begin
      w_state_next = ST_IDLE;
      w_count_next = '0;
    end else if (bus.i_rising && bus.i_falling) begin
      w_state_next = ST_IDLE;
      w_count_next = '0;
      w_error_next = 1'b1;
    end else if (bus.i_rising || bus.i_falling) begin
      w_count_next = '0;
      unique case (r_state)
        ST_IDLE: begin
          w_state_next = bus.i_rising ? ST_HIGH : ST_LOW;
        end
        ST_HIGH: begin
          if (bus.i_falling) begin
            w_high_width_next = r_count;
            w_high_valid_next = 1'b1;
            w_state_next      = ST_LOW;
          end else begin
            w_error_next = 1'b1;
          end
        end
        ST_LOW: begin
          if (bus.i_rising) begin
            w_low_width_next = r_count;
            w_low_valid_next = 1'b1;
            w_state_next     = ST_HIGH;
          end else begin
            w_error_next = 1'b1;
          end
        end
        ST_BREAK: begin
          // The break is not a bit low-time, so it is never captured.
          if (bus.i_rising) begin
            w_frame_start_next = 1'b1;
            w_state_next       = ST_HIGH;
          end else begin
            w_error_next = 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else begin
      if (bus.i_count_enable && (r_count != CNT_MAX)) begin
        w_count_next = r_count + 1'b1;
      end
      // Enter BREAK on the same edge the counter lands on the threshold, so
      // o_break and o_count == RESET_TICKS are visible together.
      if ((r_state == ST_LOW) && (w_count_next == BREAK_CNT)) begin
        w_state_next = ST_BREAK;
        w_break_next = 1'b1;
      end
    end
  end

  assign bus.o_count       = r_count;
  assign bus.o_saturated   = (r_count == CNT_MAX);
  assign bus.o_high_width  = r_high_width;
  assign bus.o_high_valid  = r_high_valid;
  assign bus.o_low_width   = r_low_width;
  assign bus.o_low_valid   = r_low_valid;
  assign bus.o_break       = r_break;
  assign bus.o_frame_start = r_frame_start;
  assign bus.o_error       = r_error;
  assign bus.o_state       = r_state;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Self-checking bench for pulse_width_meter (WIDTH=10, RESET_TICKS=400).
// Strobe expectations are queued as stimulus is driven and matched by a monitor.
// Inputs change 1 ns after the rising edge; outputs are sampled then or on the falling edge.
module tb_pulse_width_meter;

  localparam int W = 10;

  localparam int K_HIGH  = 0;
  localparam int K_LOW   = 1;
  localparam int K_BREAK = 2;
  localparam int K_FRAME = 3;
  localparam int K_ERROR = 4;

  typedef struct {
    int         kind;
    bit         chk_val;
    logic [W-1:0] val;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
  int   n_brk;
  exp_t sb[$];

  pulse_width_meter_if #(.WIDTH(W)) bus ();

  pulse_width_meter #(.WIDTH(W), .RESET_TICKS(400)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every strobe seen must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [4:0]   strb;
    logic [W-1:0] val [5];
    exp_t         e;
    strb = {bus.o_error, bus.o_frame_start, bus.o_break, bus.o_low_valid, bus.o_high_valid};
    val[K_HIGH]  = bus.o_high_width;
    val[K_LOW]   = bus.o_low_width;
    val[K_BREAK] = bus.o_count;
    val[K_FRAME] = '0;
    val[K_ERROR] = '0;
    for (int k = 0; k < 5; k++) begin
      if (strb[k]) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_strobe kind=%0d value=%0d expected=no strobe", k, val[k]);
        end else begin
          e = sb.pop_front();
          if (e.kind != k || (e.chk_val && val[k] !== e.val)) begin
            n_err++;
            $display("FAIL sb_strobe got kind=%0d value=%0d expected kind=%0d value=%0d",
                     k, val[k], e.kind, e.val);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int kind, input bit chk, input logic [W-1:0] v);
    exp_t e;
    e.kind = kind;
    e.chk_val = chk;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.i_count_enable = 1'b1;
    bus.i_rising = 1'b0;
    bus.i_falling = 1'b0;
    bus.i_clear = 1'b0;
    #1;
    n_vec++;
    if ({bus.o_count, bus.o_state, bus.o_high_width, bus.o_low_width, bus.o_saturated} !== '0) begin
      n_err++;
      $display("FAIL reset_state count=%0d state=%0d hw=%0d lw=%0d sat=%b expected all 0",
               bus.o_count, bus.o_state, bus.o_high_width, bus.o_low_width, bus.o_saturated);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_high_capture();
    bus.i_rising = 1'b1; tick(); bus.i_rising = 1'b0;
    repeat (20) tick();
    n_vec++;
    if (bus.o_count !== 10'd20) begin
      n_err++; $display("FAIL high_count got=%0d expected=20", bus.o_count);
    end
    expect_evt(K_HIGH, 1'b1, 10'd20);
    bus.i_falling = 1'b1; tick(); bus.i_falling = 1'b0;
    n_vec++;
    if (bus.o_high_valid !== 1'b1 || bus.o_high_width !== 10'd20 || bus.o_state !== 2'd2
        || bus.o_count !== 10'd0) begin
      n_err++;
      $display("FAIL high_capture valid=%b width=%0d state=%0d count=%0d expected 1/20/2/0",
               bus.o_high_valid, bus.o_high_width, bus.o_state, bus.o_count);
    end
    tick();
    n_vec++;
    if (bus.o_high_valid !== 1'b0) begin
      n_err++; $display("FAIL high_valid_one_cycle got=%b expected=0", bus.o_high_valid);
    end
  endtask

  task automatic test_low_capture();
    repeat (44) tick();
    expect_evt(K_LOW, 1'b1, 10'd45);
    bus.i_rising = 1'b1; tick(); bus.i_rising = 1'b0;
    n_vec++;
    if (bus.o_low_valid !== 1'b1 || bus.o_low_width !== 10'd45 || bus.o_high_width !== 10'd20
        || bus.o_state !== 2'd1) begin
      n_err++;
      $display("FAIL low_capture valid=%b lw=%0d hw=%0d state=%0d expected 1/45/20/1",
               bus.o_low_valid, bus.o_low_width, bus.o_high_width, bus.o_state);
    end
    tick();
    n_vec++;
    if (bus.o_low_valid !== 1'b0) begin
      n_err++; $display("FAIL low_valid_one_cycle got=%b expected=0", bus.o_low_valid);
    end
  endtask

  task automatic test_break();
    repeat (9) tick();
    expect_evt(K_HIGH, 1'b1, 10'd10);
    bus.i_falling = 1'b1; tick(); bus.i_falling = 1'b0;
    expect_evt(K_BREAK, 1'b1, 10'd400);
    n_brk = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (bus.o_break === 1'b1) n_brk++;
    end
    n_vec++;
    if (n_brk != 1) begin
      n_err++; $display("FAIL break_once pulses=%0d expected=1", n_brk);
    end
    n_vec++;
    if (bus.o_count !== 10'd1023 || bus.o_saturated !== 1'b1 || bus.o_state !== 2'd3) begin
      n_err++;
      $display("FAIL break_saturate count=%0d sat=%b state=%0d expected 1023/1/3",
               bus.o_count, bus.o_saturated, bus.o_state);
    end
  endtask

  task automatic test_frame_start();
    expect_evt(K_FRAME, 1'b0, '0);
    bus.i_rising = 1'b1; tick(); bus.i_rising = 1'b0;
    n_vec++;
    if (bus.o_frame_start !== 1'b1 || bus.o_low_valid !== 1'b0 || bus.o_state !== 2'd1
        || bus.o_count !== 10'd0 || bus.o_low_width !== 10'd45) begin
      n_err++;
      $display("FAIL frame_start fs=%b lv=%b state=%0d count=%0d lw=%0d expected 1/0/1/0/45",
               bus.o_frame_start, bus.o_low_valid, bus.o_state, bus.o_count, bus.o_low_width);
    end
    tick();
    n_vec++;
    if (bus.o_frame_start !== 1'b0 || bus.o_saturated !== 1'b0) begin
      n_err++;
      $display("FAIL frame_start_one_cycle fs=%b sat=%b expected 0/0",
               bus.o_frame_start, bus.o_saturated);
    end
  endtask

  task automatic test_simultaneous_edges();
    repeat (6) tick();
    n_vec++;
    if (bus.o_count !== 10'd7) begin
      n_err++; $display("FAIL simul_precount got=%0d expected=7", bus.o_count);
    end
    expect_evt(K_ERROR, 1'b0, '0);
    bus.i_rising = 1'b1; bus.i_falling = 1'b1; bus.i_count_enable = 1'b1;
    tick();
    bus.i_rising = 1'b0; bus.i_falling = 1'b0;
    n_vec++;
    if (bus.o_error !== 1'b1 || bus.o_count !== 10'd0 || bus.o_state !== 2'd0
        || bus.o_high_valid !== 1'b0 || bus.o_low_valid !== 1'b0) begin
      n_err++;
      $display("FAIL simul_edges err=%b count=%0d state=%0d hv=%b lv=%b expected 1/0/0/0/0",
               bus.o_error, bus.o_count, bus.o_state, bus.o_high_valid, bus.o_low_valid);
    end
  endtask

  task automatic test_clear_priority();
    bus.i_rising = 1'b1; tick(); bus.i_rising = 1'b0;
    repeat (3) tick();
    bus.i_clear = 1'b1; bus.i_falling = 1'b1;
    tick();
    bus.i_clear = 1'b0; bus.i_falling = 1'b0;
    n_vec++;
    if (bus.o_state !== 2'd0 || bus.o_count !== 10'd0 || bus.o_high_width !== 10'd10
        || bus.o_low_width !== 10'd45 || bus.o_high_valid !== 1'b0 || bus.o_error !== 1'b0) begin
      n_err++;
      $display("FAIL clear_priority state=%0d count=%0d hw=%0d lw=%0d hv=%b err=%b expected 0/0/10/45/0/0",
               bus.o_state, bus.o_count, bus.o_high_width, bus.o_low_width,
               bus.o_high_valid, bus.o_error);
    end
  endtask

  task automatic test_low_error();
    bus.i_falling = 1'b1; tick(); bus.i_falling = 1'b0;
    repeat (5) tick();
    expect_evt(K_ERROR, 1'b0, '0);
    bus.i_falling = 1'b1; tick(); bus.i_falling = 1'b0;
    n_vec++;
    if (bus.o_error !== 1'b1 || bus.o_state !== 2'd2 || bus.o_count !== 10'd0) begin
      n_err++;
      $display("FAIL low_double_falling err=%b state=%0d count=%0d expected 1/2/0",
               bus.o_error, bus.o_state, bus.o_count);
    end
    bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.i_rising = 1'b1; tick(); bus.i_rising = 1'b0;
    repeat (100) tick();
    n_vec++;
    if (bus.o_count !== 10'd100 || bus.o_state !== 2'd1) begin
      n_err++;
      $display("FAIL pre_reset count=%0d state=%0d expected 100/1", bus.o_count, bus.o_state);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.o_count, bus.o_state, bus.o_high_width, bus.o_low_width, bus.o_saturated,
         bus.o_high_valid, bus.o_low_valid, bus.o_break, bus.o_frame_start, bus.o_error} !== '0) begin
      n_err++;
      $display("FAIL async_reset count=%0d state=%0d hw=%0d lw=%0d strobes=%b expected all 0",
               bus.o_count, bus.o_state, bus.o_high_width, bus.o_low_width,
               {bus.o_high_valid, bus.o_low_valid, bus.o_break, bus.o_frame_start, bus.o_error});
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    bus.i_rising = 1'b1; tick(); bus.i_rising = 1'b0;
    n_vec++;
    if (bus.o_state !== 2'd1 || bus.o_high_valid !== 1'b0 || bus.o_high_width !== 10'd0
        || bus.o_count !== 10'd0) begin
      n_err++;
      $display("FAIL post_reset_rising state=%0d hv=%b hw=%0d count=%0d expected 1/0/0/0",
               bus.o_state, bus.o_high_valid, bus.o_high_width, bus.o_count);
    end
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_brk = 0;
    test_reset();
    test_high_capture();
    test_low_capture();
    test_break();
    test_frame_start();
    test_simultaneous_edges();
    test_clear_priority();
    test_low_error();
    test_async_reset();
    @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover pending=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
